// File: rtl/pool_sched_pkg.sv
// +----------------------------------------------------------------------+
// | pool_sched_pkg : shared constants for the pool memory owner scheduler |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

package pool_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PROD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_CONS  = 2'd3
  } sched_state_e;

  localparam logic OWNER_PROD = 1'b0;
  localparam logic OWNER_CONS = 1'b1;

  // Wide enough for the largest legal drain length (15).
  localparam int DRAIN_CNT_WIDTH = 4;

endpackage : pool_sched_pkg

`default_nettype wire

// File: rtl/pool_port_mux.sv
// +----------------------------------------------------------------------+
// | pool_port_mux : registered 2:1 mux of address and strobes, one port   |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

module pool_port_mux
  import pool_sched_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_owner,
  input  logic                  i_idle,
  input  logic [ADDR_WIDTH-1:0] i_prod_addr,
  input  logic                  i_prod_rden,
  input  logic                  i_prod_wren,
  input  logic [ADDR_WIDTH-1:0] i_cons_addr,
  input  logic                  i_cons_rden,
  input  logic                  i_cons_wren,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_rden,
  output logic                  o_wren
);

  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_rden;
  logic                  r_wren;

  // Idle keeps the address steady and suppresses both strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
      r_rden <= 1'b0;
      r_wren <= 1'b0;
    end else if (i_idle) begin
      r_rden <= 1'b0;
      r_wren <= 1'b0;
    end else if (i_owner == OWNER_CONS) begin
      r_addr <= i_cons_addr;
      r_rden <= i_cons_rden;
      r_wren <= i_cons_wren;
    end else begin
      r_addr <= i_prod_addr;
      r_rden <= i_prod_rden;
      r_wren <= i_prod_wren;
    end
  end

  assign o_addr = r_addr;
  assign o_rden = r_rden;
  assign o_wren = r_wren;

endmodule : pool_port_mux

`default_nettype wire

// File: rtl/pool_mem_owner_sched.sv
// +----------------------------------------------------------------------+
// | pool_mem_owner_sched : hands one pool memory bank from producer to    |
// | consumer layer, with drain gap, frame counter and sticky errors.      |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

module pool_mem_owner_sched
  import pool_sched_pkg::*;
#(
  parameter int POOL_ADDR_WIDTH = 10,
  parameter int DRAIN_CYCLES    = 3,
  parameter int FRAME_CNT_WIDTH = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       abort,
  output logic                       prod_enable,
  input  logic                       prod_done,
  input  logic [POOL_ADDR_WIDTH-1:0] prod_addr_a,
  input  logic [POOL_ADDR_WIDTH-1:0] prod_addr_b,
  input  logic                       prod_rden_a,
  input  logic                       prod_rden_b,
  input  logic                       prod_wren_a,
  input  logic                       prod_wren_b,
  output logic                       cons_enable,
  input  logic                       cons_done,
  input  logic [POOL_ADDR_WIDTH-1:0] cons_addr_a,
  input  logic [POOL_ADDR_WIDTH-1:0] cons_addr_b,
  input  logic                       cons_rden_a,
  input  logic                       cons_rden_b,
  input  logic                       cons_wren_a,
  input  logic                       cons_wren_b,
  output logic [POOL_ADDR_WIDTH-1:0] mem_addr_a,
  output logic [POOL_ADDR_WIDTH-1:0] mem_addr_b,
  output logic                       mem_rden_a,
  output logic                       mem_rden_b,
  output logic                       mem_wren_a,
  output logic                       mem_wren_b,
  output logic                       owner,
  output logic                       busy,
  output logic [FRAME_CNT_WIDTH-1:0] frame_count,
  output logic                       err_start_drop,
  output logic                       err_collision
);

  localparam logic [DRAIN_CNT_WIDTH-1:0] C_DRAIN_LAST = DRAIN_CNT_WIDTH'(DRAIN_CYCLES - 1);

  sched_state_e                r_state;
  sched_state_e                w_next;
  logic [DRAIN_CNT_WIDTH-1:0]  r_drain_cnt;
  logic [FRAME_CNT_WIDTH-1:0]  r_frame_cnt;
  logic                        r_prod_en;
  logic                        r_cons_en;
  logic                        r_owner;
  logic                        r_busy;
  logic                        r_err_start;
  logic                        r_err_coll;
  logic                        w_drain_last;
  logic                        w_frame_done;
  logic                        w_mux_idle;
  logic                        w_mux_owner;
  logic                        w_collision;

  assign w_drain_last = (r_drain_cnt == C_DRAIN_LAST);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (start)        w_next = ST_PROD;
      ST_PROD:  if (prod_done)    w_next = ST_DRAIN;
      ST_DRAIN: if (w_drain_last) w_next = ST_CONS;
      ST_CONS:  if (cons_done)    w_next = ST_IDLE;
      default:                    w_next = ST_IDLE;
    endcase
    if (abort) begin
      w_next = ST_IDLE;
    end
  end

  assign w_frame_done = (r_state == ST_CONS) && cons_done && !abort;

  // Strobes are blocked on the cycle we leave for IDLE so nothing from the
  // departing owner leaks into the IDLE cycle.
  assign w_mux_idle  = (r_state == ST_IDLE) || (w_next == ST_IDLE);
  assign w_mux_owner = (r_state == ST_CONS) ? OWNER_CONS : OWNER_PROD;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_drain_cnt <= '0;
      r_frame_cnt <= '0;
      r_prod_en   <= 1'b0;
      r_cons_en   <= 1'b0;
      r_owner     <= OWNER_PROD;
      r_busy      <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_prod_en <= (w_next == ST_PROD);
      r_cons_en <= (w_next == ST_CONS);
      r_owner   <= (w_next == ST_CONS) ? OWNER_CONS : OWNER_PROD;
      r_busy    <= (w_next != ST_IDLE);
      if ((r_state == ST_DRAIN) && (w_next == ST_DRAIN)) begin
        r_drain_cnt <= r_drain_cnt + DRAIN_CNT_WIDTH'(1);
      end else begin
        r_drain_cnt <= '0;
      end
      if (w_frame_done) begin
        r_frame_cnt <= r_frame_cnt + FRAME_CNT_WIDTH'(1);
      end
    end
  end

  pool_port_mux #(
    .ADDR_WIDTH (POOL_ADDR_WIDTH)
  ) u_mux_a (
    .clk         (clock),
    .rst_n       (reset),
    .i_owner     (w_mux_owner),
    .i_idle      (w_mux_idle),
    .i_prod_addr (prod_addr_a),
    .i_prod_rden (prod_rden_a),
    .i_prod_wren (prod_wren_a),
    .i_cons_addr (cons_addr_a),
    .i_cons_rden (cons_rden_a),
    .i_cons_wren (cons_wren_a),
    .o_addr      (mem_addr_a),
    .o_rden      (mem_rden_a),
    .o_wren      (mem_wren_a)
  );

  pool_port_mux #(
    .ADDR_WIDTH (POOL_ADDR_WIDTH)
  ) u_mux_b (
    .clk         (clock),
    .rst_n       (reset),
    .i_owner     (w_mux_owner),
    .i_idle      (w_mux_idle),
    .i_prod_addr (prod_addr_b),
    .i_prod_rden (prod_rden_b),
    .i_prod_wren (prod_wren_b),
    .i_cons_addr (cons_addr_b),
    .i_cons_rden (cons_rden_b),
    .i_cons_wren (cons_wren_b),
    .o_addr      (mem_addr_b),
    .o_rden      (mem_rden_b),
    .o_wren      (mem_wren_b)
  );

  assign w_collision = mem_wren_a && mem_wren_b && (mem_addr_a == mem_addr_b);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_err_start <= 1'b0;
      r_err_coll  <= 1'b0;
    end else begin
      if (start && (r_state != ST_IDLE)) begin
        r_err_start <= 1'b1;
      end
      if (w_collision) begin
        r_err_coll <= 1'b1;
      end
    end
  end

  assign prod_enable    = r_prod_en;
  assign cons_enable    = r_cons_en;
  assign owner          = r_owner;
  assign busy           = r_busy;
  assign frame_count    = r_frame_cnt;
  assign err_start_drop = r_err_start;
  assign err_collision  = r_err_coll;

endmodule : pool_mem_owner_sched

`default_nettype wire
